ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: serialises one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) onto the open-drain PS/2 clock/data pair and checks the device acknowledge. It sits beside the PS/2 keyboard receiver on the same pins. Its `busy` output gates that receiver so it ignores host-generated traffic. Pad logic turns `*_drive_low` into open-drain pulls.

---
 rtl/ps2_host_tx_if.sv | 34 +++
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx_if
//  Description : Command handshake and status bundle for the PS/2 host
//                transmitter (byte request, ready, busy, done/error pulses).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output error
    );
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : Host-to-device PS/2 transmitter. Inhibits the bus, issues a
//                request-to-send, shifts out start/data/parity/stop on the
//                device's falling clock edges and checks the device ACK.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         clk_in,
    input  logic         reset,
    ps2_host_tx_if.slave tx_if,
    input  logic         ps2_clock,
    input  logic         ps2_data,
    output logic         ps2_clock_drive_low,
    output logic         ps2_data_drive_low
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_INHIBIT   = 3'd1;
    localparam logic [2:0] c_START     = 3'd2;
    localparam logic [2:0] c_SEND      = 3'd3;
    localparam logic [2:0] c_ACK       = 3'd4;
    localparam logic [2:0] c_WAIT_IDLE = 3'd5;

    // One counter serves the inhibit, start and timeout phases, so it is
    // sized for the largest of the three.
    localparam int c_MAX_IS     = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int c_MAX_CYCLES = (TIMEOUT_CYCLES > c_MAX_IS) ? TIMEOUT_CYCLES : c_MAX_IS;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_INHIBIT_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_START_LAST   = c_CNT_W'(START_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT      = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]         c_STOP_IDX     = 4'd9;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bit_idx;
    logic [8:0]         r_shift;
    logic               r_clock_low;
    logic               r_data_low;
    logic               r_clk_meta;
    logic               r_clk_sync;
    logic               r_clk_prev;
    logic               r_data_meta;
    logic               r_data_sync;

    logic w_fall;
    logic w_timed;
    logic w_timeout;
    logic w_accept;
    logic w_ack_nak;
    logic w_done;

    // Two-flop synchronisers for both pins plus a history flop for edge detect
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clock;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data;
            r_data_sync <= r_data_meta;
        end
    end

    // Edge detect, timeout and completion decode feeding the FSM and pulses
    always_comb begin
        w_fall    = r_clk_prev & ~r_clk_sync;
        w_timed   = (r_state == c_SEND) || (r_state == c_ACK) || (r_state == c_WAIT_IDLE);
        w_timeout = w_timed && (r_cnt == c_TIMEOUT);
        w_accept  = (r_state == c_IDLE) && tx_if.tx_valid;
        w_ack_nak = (r_state == c_ACK) && !w_timeout && w_fall && r_data_sync;
        w_done    = (r_state == c_WAIT_IDLE) && !w_timeout && r_clk_sync && r_data_sync;
    end

    // Frame sequencer: owns state, cycle counter, bit index and line drives
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_clock_low <= 1'b0;
            r_data_low  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        // Latch byte and odd parity so later tx_data changes are ignored
                        r_shift     <= {~^tx_if.tx_data, tx_if.tx_data};
                        r_bit_idx   <= '0;
                        r_clock_low <= 1'b1;
                        r_state     <= c_INHIBIT;
                    end
                end
                c_INHIBIT: begin
                    if (r_cnt == c_INHIBIT_LAST) begin
                        r_cnt      <= '0;
                        r_data_low <= 1'b1;
                        r_state    <= c_START;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_START: begin
                    if (r_cnt == c_START_LAST) begin
                        // Clock release: data stays low as the start bit
                        r_cnt       <= '0;
                        r_clock_low <= 1'b0;
                        r_bit_idx   <= '0;
                        r_state     <= c_SEND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_SEND: begin
                    if (w_timeout) begin
                        r_clock_low <= 1'b0;
                        r_data_low  <= 1'b0;
                        r_state     <= c_IDLE;
                    end else if (w_fall) begin
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx == c_STOP_IDX) begin
                            // Tenth edge: release data for the stop bit
                            r_data_low <= 1'b0;
                            r_state    <= c_ACK;
                        end else begin
                            r_data_low <= ~r_shift[0];
                            r_shift    <= {1'b0, r_shift[8:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ACK: begin
                    if (w_timeout) begin
                        r_clock_low <= 1'b0;
                        r_data_low  <= 1'b0;
                        r_state     <= c_IDLE;
                    end else if (w_fall) begin
                        r_cnt   <= '0;
                        r_state <= r_data_sync ? c_IDLE : c_WAIT_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_WAIT_IDLE: begin
                    if (w_timeout) begin
                        r_clock_low <= 1'b0;
                        r_data_low  <= 1'b0;
                        r_state     <= c_IDLE;
                    end else if (w_done) begin
                        r_state <= c_IDLE;
                    end else if (w_fall) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_clock_low <= 1'b0;
                    r_data_low  <= 1'b0;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    // Status and pad-drive outputs; done/error flag the final transition cycle
    always_comb begin
        tx_if.tx_ready      = (r_state == c_IDLE);
        tx_if.busy          = (r_state != c_IDLE);
        tx_if.done          = w_done;
        tx_if.error         = w_timeout | w_ack_nak;
        ps2_clock_drive_low = r_clock_low;
        ps2_data_drive_low  = r_data_low;
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Directed testbench for ps2_host_tx with an open-drain PS/2
//                device model (scaled-down timing parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH   = 40;
    localparam int STA   = 8;
    localparam int TMO   = 300;
    localparam int HALF  = 20;
    localparam int LIMIT = 2000;

    logic clk_in   = 1'b0;
    logic reset    = 1'b1;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clock;
    logic ps2_data;
    logic ps2_clock_drive_low;
    logic ps2_data_drive_low;

    int   n_cmp       = 0;
    int   n_mis       = 0;
    int   n_done      = 0;
    int   n_errp      = 0;
    int   n_both      = 0;
    int   n_ready_bad = 0;
    int   n_acc       = 0;
    logic prev_pulse  = 1'b0;

    ps2_host_tx_if u_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_CYCLES   (STA),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk_in              (clk_in),
        .reset               (reset),
        .tx_if               (u_if),
        .ps2_clock           (ps2_clock),
        .ps2_data            (ps2_data),
        .ps2_clock_drive_low (ps2_clock_drive_low),
        .ps2_data_drive_low  (ps2_data_drive_low)
    );

    always #5 clk_in = ~clk_in;

    // Open-drain wired-AND of host pulls and device lines
    assign ps2_clock = dev_clk  & ~ps2_clock_drive_low;
    assign ps2_data  = dev_data & ~ps2_data_drive_low;

    // Pulse and accept bookkeeping sampled mid-cycle
    always @(negedge clk_in) begin
        if (u_if.done)                   n_done <= n_done + 1;
        if (u_if.error)                  n_errp <= n_errp + 1;
        if (u_if.done && u_if.error)     n_both <= n_both + 1;
        if ((u_if.done || u_if.error) && u_if.tx_ready) n_ready_bad <= n_ready_bad + 1;
        if (prev_pulse && !u_if.tx_ready) n_ready_bad <= n_ready_bad + 1;
        if (!reset && u_if.tx_valid && u_if.tx_ready) n_acc <= n_acc + 1;
        prev_pulse <= u_if.done || u_if.error;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 2 ms");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_if.tx_data  = b;
        u_if.tx_valid = 1'b1;
        tick();
        u_if.tx_valid = 1'b0;
    endtask

    task automatic wait_release(input string tag);
        int n;
        n = 0;
        while (!(ps2_clock_drive_low == 1'b0 && ps2_data_drive_low == 1'b1) && n < LIMIT) begin
            tick();
            n++;
        end
        check(tag, 32'(n < LIMIT), 32'd1);
    endtask

    // Device clocks n_edges falling edges, reading data at the end of each low phase
    task automatic device_run(input int n_edges, input logic ack_bit,
                              output logic [10:0] seen, output logic busy_all);
        seen     = '0;
        busy_all = 1'b1;
        repeat (5) tick();
        seen[0] = ps2_data;
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11) dev_data = ack_bit;
            dev_clk = 1'b0;
            repeat (HALF) tick();
            if (k <= 10) begin
                seen[k]  = ps2_data;
                busy_all = busy_all & u_if.busy;
            end
            dev_clk  = 1'b1;
            dev_data = 1'b1;
            repeat (HALF) tick();
        end
    endtask

    initial begin
        logic [10:0] seen;
        logic        ball;
        logic        hold_ok;
        int          cnt;
        int          d0;
        int          e0;
        int          a0;

        u_if.tx_data  = 8'h00;
        u_if.tx_valid = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_tx_ready", u_if.tx_ready, 1);
        check("rst_busy", u_if.busy, 0);
        check("rst_done", u_if.done, 0);
        check("rst_error", u_if.error, 0);
        check("rst_clk_drv", ps2_clock_drive_low, 0);
        check("rst_dat_drv", ps2_data_drive_low, 0);
        reset = 1'b0;
        repeat (3) tick();

        // 0xED with inhibit/start timing
        d0 = n_done; e0 = n_errp;
        send_byte(8'hED);
        check("acc_clk_drv", ps2_clock_drive_low, 1);
        check("acc_busy", u_if.busy, 1);
        check("acc_tx_ready", u_if.tx_ready, 0);
        check("acc_dat_drv", ps2_data_drive_low, 0);
        cnt = 0; hold_ok = 1'b1;
        while (!ps2_data_drive_low && cnt < LIMIT) begin
            hold_ok &= ps2_clock_drive_low;
            tick();
            cnt++;
        end
        check("inhibit_cycles", cnt, INH);
        cnt = 0;
        while (ps2_clock_drive_low && cnt < LIMIT) begin
            hold_ok &= ps2_data_drive_low;
            tick();
            cnt++;
        end
        check("start_cycles", cnt, STA);
        check("hold_levels", hold_ok, 1);
        device_run(11, 1'b0, seen, ball);
        check("ed_bits", seen, {2'b11, 8'hED, 1'b0});
        check("ed_busy", ball, 1);
        check("ed_done_cnt", n_done - d0, 1);
        check("ed_err_cnt", n_errp - e0, 0);
        check("ed_clk_drv", ps2_clock_drive_low, 0);
        check("ed_dat_drv", ps2_data_drive_low, 0);
        check("ed_ready", u_if.tx_ready, 1);

        // 0xF4: parity 0
        d0 = n_done; e0 = n_errp;
        send_byte(8'hF4);
        wait_release("f4_release");
        device_run(11, 1'b0, seen, ball);
        check("f4_bits", seen, {2'b10, 8'hF4, 1'b0});
        check("f4_done_cnt", n_done - d0, 1);
        check("f4_err_cnt", n_errp - e0, 0);
        check("f4_drv", {ps2_clock_drive_low, ps2_data_drive_low}, 0);

        // 0x00 with device NAK
        d0 = n_done; e0 = n_errp;
        send_byte(8'h00);
        wait_release("nak_release");
        device_run(11, 1'b1, seen, ball);
        check("nak_bits", seen, {2'b11, 8'h00, 1'b0});
        check("nak_err_cnt", n_errp - e0, 1);
        check("nak_done_cnt", n_done - d0, 0);
        check("nak_ready", u_if.tx_ready, 1);

        // Device never clocks: timeout from clock release
        e0 = n_errp;
        send_byte(8'hA5);
        wait_release("to_release");
        cnt = 0;
        while (!u_if.error && cnt < LIMIT) begin
            tick();
            cnt++;
        end
        check("to_cycles", cnt, TMO);
        tick();
        check("to_drv", {ps2_clock_drive_low, ps2_data_drive_low}, 0);
        check("to_ready", u_if.tx_ready, 1);
        check("to_err_cnt", n_errp - e0, 1);

        // Asynchronous reset after edge 5 of 0xFF, then a clean 0xF4
        send_byte(8'hFF);
        wait_release("rst_mid_release");
        device_run(5, 1'b0, seen, ball);
        check("rst_mid_drv_before", ps2_data_drive_low, 0);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_drv", {ps2_clock_drive_low, ps2_data_drive_low}, 0);
        check("rst_mid_ready", u_if.tx_ready, 1);
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        d0 = n_done; e0 = n_errp;
        send_byte(8'hF4);
        wait_release("post_rst_release");
        device_run(11, 1'b0, seen, ball);
        check("post_rst_bits", seen, {2'b10, 8'hF4, 1'b0});
        check("post_rst_done", n_done - d0, 1);
        check("post_rst_err", n_errp - e0, 0);

        // tx_valid held high, tx_data changed mid-frame
        d0 = n_done; a0 = n_acc;
        u_if.tx_data  = 8'h3C;
        u_if.tx_valid = 1'b1;
        tick();
        wait_release("hold1_release");
        u_if.tx_data = 8'hC3;
        device_run(11, 1'b0, seen, ball);
        check("hold1_bits", seen, {2'b11, 8'h3C, 1'b0});
        check("hold1_busy", ball, 1);
        wait_release("hold2_release");
        u_if.tx_valid = 1'b0;
        device_run(11, 1'b0, seen, ball);
        check("hold2_bits", seen, {2'b11, 8'hC3, 1'b0});
        check("hold2_busy", ball, 1);
        repeat (10) tick();
        check("hold_acc_cnt", n_acc - a0, 2);
        check("hold_done_cnt", n_done - d0, 2);
        check("hold_ready", u_if.tx_ready, 1);

        // Global pulse properties
        check("pulse_both", n_both, 0);
        check("pulse_ready", n_ready_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
